// File: rtl/sw_capture_ctrl.sv
// Push-button capture stage for the seven-segment display: synchronise and debounce BTNY,
// short press latches the switches into disp_val, long press toggles the blank request.
module sw_capture_ctrl #(
  parameter int WIDTH       = 16,
  parameter int DB_CYCLES   = 1000000,
  parameter int LONG_CYCLES = 100000000
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn,
  output logic [WIDTH-1:0] disp_val,
  output logic             blank,
  output logic             upd,
  output logic             btn_db
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam int HW  = $clog2(LONG_CYCLES);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONG_CYCLES - 1);
  // Fire on the cycle hold_cnt steps onto LONG_CYCLES-1, so upd lands LONG_CYCLES after btn_db rises.
  localparam logic [HW-1:0]  HOLD_FIRE = HW'(LONG_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, PRESS, LONG} state_t;

  logic           s1, s2;
  logic [DBW-1:0] db_cnt;
  logic [HW-1:0]  hold_cnt;
  state_t         state;

  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (s2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      disp_val <= '0;
      blank    <= 1'b0;
      upd      <= 1'b0;
    end else begin
      upd <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_db) begin
            state    <= PRESS;
            hold_cnt <= '0;
          end
        end
        PRESS: begin
          if (!btn_db) begin
            disp_val <= sw;
            upd      <= 1'b1;
            state    <= IDLE;
          end else begin
            if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == HOLD_FIRE) begin
              blank <= ~blank;
              upd   <= 1'b1;
              state <= LONG;
            end
          end
        end
        LONG: begin
          if (!btn_db) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_capture_ctrl.sv
// Scoreboard bench for sw_capture_ctrl: stimulus queues the expected upd events
// (value, blank, cycle), a negedge monitor pops and checks them as upd fires.
module tb_sw_capture_ctrl;
  localparam int W = 16;

  logic         gclk = 1'b0;
  logic         grst_n;
  logic [W-1:0] sw;
  logic         btn;
  logic [W-1:0] disp_val;
  logic         blank, upd, btn_db;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic upd_prev = 1'b0;

  typedef struct {
    logic [W-1:0] dv;
    logic         bl;
    int           at;
  } exp_t;
  exp_t q[$];

  sw_capture_ctrl #(.WIDTH(W), .DB_CYCLES(4), .LONG_CYCLES(20)) dut (
    .gclk(gclk), .grst_n(grst_n), .sw(sw), .btn(btn),
    .disp_val(disp_val), .blank(blank), .upd(upd), .btn_db(btn_db)
  );

  always #5 gclk = ~gclk;
  always @(posedge gclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every upd pulse must match the head of the scoreboard.
  always @(negedge gclk) begin
    if (upd === 1'b1) begin
      chk("upd_not_back_to_back", {31'd0, upd_prev}, 32'd0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_upd at cyc %0d: disp_val=%h blank=%b, expected no upd",
                 cyc, disp_val, blank);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("upd_disp_val", {16'd0, disp_val}, {16'd0, e.dv});
        chk("upd_blank", {31'd0, blank}, {31'd0, e.bl});
        chk("upd_cycle", cyc, e.at);
      end
    end
    upd_prev = upd;
  end

  task automatic tick(input int k);
    repeat (k) @(posedge gclk);
    #1;
  endtask

  // btn sampled at edge n+1, btn_db rises after n+6; short upd 1 cycle after btn_db falls,
  // long upd 20 cycles after btn_db rises.
  task automatic press(input logic [W-1:0] dv, input logic bl, input int hold, input bit is_long);
    exp_t e;
    e.dv = dv;
    e.bl = bl;
    e.at = is_long ? cyc + 26 : cyc + hold + 7;
    q.push_back(e);
    btn = 1'b1;
    tick(hold);
    btn = 1'b0;
    tick(15);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    // Reset with a held button and live switches.
    grst_n = 1'b0;
    sw     = 16'hABCD;
    btn    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge gclk);
      chk("rst_disp_val", {16'd0, disp_val}, 32'd0);
      chk("rst_blank", {31'd0, blank}, 32'd0);
      chk("rst_upd", {31'd0, upd}, 32'd0);
      chk("rst_btn_db", {31'd0, btn_db}, 32'd0);
    end
    tick(1);
    btn    = 1'b0;
    grst_n = 1'b1;
    tick(10);
    chk("idle_btn_db", {31'd0, btn_db}, 32'd0);

    // Short press with debounce latency check.
    sw = 16'hABCD;
    n  = cyc;
    begin
      exp_t e;
      e.dv = 16'hABCD; e.bl = 1'b0; e.at = n + 17;
      q.push_back(e);
    end
    btn = 1'b1;
    tick(5);
    chk("db_latency_before", {31'd0, btn_db}, 32'd0);
    tick(1);
    chk("db_latency_after", {31'd0, btn_db}, 32'd1);
    tick(4);
    btn = 1'b0;
    tick(15);
    chk("short_disp_val", {16'd0, disp_val}, 32'h0000ABCD);
    chk("short_blank", {31'd0, blank}, 32'd0);

    // Bounce shorter than the window never reaches btn_db.
    for (int i = 0; i < 4; i++) begin
      btn = ~i[0];
      for (int j = 0; j < 2; j++) begin
        tick(1);
        chk("bounce_btn_db", {31'd0, btn_db}, 32'd0);
      end
    end
    btn = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick(1);
      chk("bounce_settle_btn_db", {31'd0, btn_db}, 32'd0);
    end
    chk("bounce_disp_val", {16'd0, disp_val}, 32'h0000ABCD);

    // Two long presses toggle blank on then off, disp_val untouched.
    sw = 16'h1234;
    press(16'hABCD, 1'b1, 40, 1'b1);
    chk("long1_blank", {31'd0, blank}, 32'd1);
    chk("long1_disp_val", {16'd0, disp_val}, 32'h0000ABCD);
    press(16'hABCD, 1'b0, 40, 1'b1);
    chk("long2_blank", {31'd0, blank}, 32'd0);

    // Switch change alone is invisible until the next short press.
    sw = 16'h5555;
    tick(10);
    chk("swchg_disp_val", {16'd0, disp_val}, 32'h0000ABCD);
    press(16'h5555, 1'b0, 8, 1'b0);
    chk("swchg_press_disp_val", {16'd0, disp_val}, 32'h00005555);

    // Reset mid-press, button still held: re-detected and timed from reset.
    btn = 1'b1;
    tick(17);
    r = cyc;
    grst_n = 1'b0;
    tick(1);
    chk("midrst_disp_val", {16'd0, disp_val}, 32'd0);
    chk("midrst_blank", {31'd0, blank}, 32'd0);
    chk("midrst_btn_db", {31'd0, btn_db}, 32'd0);
    grst_n = 1'b1;
    begin
      exp_t e;
      e.dv = 16'h0000; e.bl = 1'b1; e.at = r + 27;
      q.push_back(e);
    end
    tick(30);
    btn = 1'b0;
    tick(15);
    chk("midrst_final_blank", {31'd0, blank}, 32'd1);
    chk("midrst_final_disp_val", {16'd0, disp_val}, 32'd0);

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
